// File: rtl/hq2x_pkg.sv
// Shared definitions for the hq2x output line store: bank count, address
// width helper and read-side FSM states.
package hq2x_pkg;

    localparam int NBANKS = 4;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_ACTIVE = 1'b1
    } rd_state_e;

    // Address ports are calc_awidth()+1 bits wide.
    function automatic int calc_awidth(input int numwords);
        return (numwords > 2) ? $clog2(numwords) - 1 : 0;
    endfunction

endpackage

// File: rtl/hq2x_out_sched_if.sv
// Write/read handshake bundle between the hq2x output scheduler (slave) and
// its producer/consumer side (master).
interface hq2x_out_sched_if #(
    parameter int AW = 0
) ();
    logic          wr_valid;
    logic          wr_ready;
    logic [AW:0]   wraddr;
    logic [1:0]    wrbuf;
    logic          wren;
    logic          rd_start;
    logic          rd_en;
    logic [AW:0]   rdaddr;
    logic [1:0]    rdbuf;
    logic          rd_valid;
    logic          rd_busy;
    logic [2:0]    level;
    logic          overflow;
    logic          underrun;

    modport master (
        output wr_valid, rd_start, rd_en,
        input  wr_ready, wraddr, wrbuf, wren,
        input  rdaddr, rdbuf, rd_valid, rd_busy, level, overflow, underrun
    );

    modport slave (
        input  wr_valid, rd_start, rd_en,
        output wr_ready, wraddr, wrbuf, wren,
        output rdaddr, rdbuf, rd_valid, rd_busy, level, overflow, underrun
    );
endinterface

// File: rtl/hq2x_out_sched_addr_ctr.sv
// Wrapping word-address counter; wrap pulses on the increment that returns
// the count from LAST to zero. clear has priority over inc.
module hq2x_addr_ctr #(
    parameter int W    = 1,
    parameter int LAST = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    localparam logic [W-1:0] LAST_V = W'(LAST);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        wrap  = inc && (cnt_q == LAST_V);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hq2x_out_sched.sv
// Sequences the 4-bank hq2x output line store: write address/bank with bank
// commit, read address/bank with bank release, occupancy and sticky flags.
module hq2x_out_sched
    import hq2x_pkg::*;
#(
    parameter int LENGTH = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            frame_start,
    hq2x_out_sched_if.slave bus
);
    localparam int NUMWORDS = LENGTH * 2;
    localparam int AWIDTH   = calc_awidth(NUMWORDS);
    localparam int LAST     = (NUMWORDS > 0) ? NUMWORDS - 1 : 0;
    localparam logic [2:0] FULL = 3'(NBANKS);

    rd_state_e   state_q, state_d;
    logic [1:0]  wrbuf_q, wrbuf_d;
    logic [1:0]  rdbuf_q, rdbuf_d;
    logic [2:0]  level_q, level_d;
    logic        overflow_q, overflow_d;
    logic        underrun_q, underrun_d;
    logic        rd_valid_q, rd_valid_d;

    logic        wr_ready;
    logic        accept;
    logic        wr_wrap;
    logic        commit;
    logic        rd_inc;
    logic        rd_launch;
    logic        rd_wrap;
    logic        rd_release;
    logic [AWIDTH:0] wraddr;
    logic [AWIDTH:0] rdaddr;

    assign wr_ready = (level_q < FULL);
    assign accept   = bus.wr_valid && wr_ready;
    assign rd_inc   = (state_q == R_ACTIVE) && bus.rd_en;

    hq2x_addr_ctr #(
        .W    (AWIDTH + 1),
        .LAST (LAST)
    ) u_wr_ctr (
        .clk   (clk),
        .rst_n (reset_n),
        .clear (frame_start),
        .inc   (accept),
        .cnt   (wraddr),
        .wrap  (wr_wrap)
    );

    hq2x_addr_ctr #(
        .W    (AWIDTH + 1),
        .LAST (LAST)
    ) u_rd_ctr (
        .clk   (clk),
        .rst_n (reset_n),
        .clear (frame_start || rd_launch),
        .inc   (rd_inc),
        .cnt   (rdaddr),
        .wrap  (rd_wrap)
    );

    assign commit     = wr_wrap && !frame_start;
    assign rd_release = rd_wrap && !frame_start;

    always_comb begin
        state_d    = state_q;
        underrun_d = underrun_q;
        rd_launch  = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (bus.rd_start) begin
                    if (level_q != 3'd0) begin
                        state_d   = R_ACTIVE;
                        rd_launch = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            R_ACTIVE: begin
                if (rd_release) begin
                    state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase

        wrbuf_d    = wrbuf_q + 2'(commit);
        rdbuf_d    = rdbuf_q + 2'(rd_release);
        // Commit and release on one edge cancel out in level.
        level_d    = level_q + 3'(commit) - 3'(rd_release);
        overflow_d = overflow_q || (bus.wr_valid && !wr_ready);
        rd_valid_d = rd_inc;

        if (frame_start) begin
            state_d    = R_IDLE;
            underrun_d = 1'b0;
            wrbuf_d    = '0;
            rdbuf_d    = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= R_IDLE;
            wrbuf_q    <= '0;
            rdbuf_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrbuf_q    <= wrbuf_d;
            rdbuf_q    <= rdbuf_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.wren     = accept;
    assign bus.wraddr   = wraddr;
    assign bus.wrbuf    = wrbuf_q;
    assign bus.rdaddr   = rdaddr;
    assign bus.rdbuf    = rdbuf_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_busy  = (state_q == R_ACTIVE);
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;
    assign bus.underrun = underrun_q;

endmodule

// File: tb/tb_hq2x_out_sched.sv
// Bench for hq2x_out_sched (LENGTH=4): directed scenarios plus random traffic
// checked every cycle against a word/bank counting model.
module tb_hq2x_out_sched;

    localparam int NW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic frame_start = 1'b0;

    hq2x_out_sched_if #(.AW(2)) bus ();

    hq2x_out_sched #(.LENGTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: total words accepted and banks released this frame.
    int wr_count = 0;
    int released = 0;
    int rd_pos   = 0;
    bit m_busy   = 1'b0;
    bit m_ov     = 1'b0;
    bit m_un     = 1'b0;
    bit m_rv     = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        wr_count = 0;
        released = 0;
        rd_pos   = 0;
        m_busy   = 1'b0;
        m_ov     = 1'b0;
        m_un     = 1'b0;
        m_rv     = 1'b0;
    endtask

    task automatic m_update(input bit v, input bit s, input bit e, input bit fs);
        int  lvl;
        bit  busy_o;
        lvl    = wr_count / NW - released;
        busy_o = m_busy;
        if (fs) begin
            m_reset();
        end else begin
            if (v) begin
                if (lvl < 4) wr_count++;
                else m_ov = 1'b1;
            end
            m_rv = e && busy_o;
            if (!busy_o) begin
                if (s) begin
                    if (lvl > 0) begin
                        m_busy = 1'b1;
                        rd_pos = 0;
                    end else begin
                        m_un = 1'b1;
                    end
                end
            end else if (e) begin
                rd_pos++;
                if (rd_pos == NW) begin
                    rd_pos = 0;
                    released++;
                    m_busy = 1'b0;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then idle the inputs.
    task automatic step(input bit v, input bit s, input bit e, input bit fs);
        bus.wr_valid = v;
        bus.rd_start = s;
        bus.rd_en    = e;
        frame_start  = fs;
        @(posedge clk);
        if (!reset_n) m_reset();
        else m_update(v, s, e, fs);
        #1;
        bus.wr_valid = 1'b0;
        bus.rd_start = 1'b0;
        bus.rd_en    = 1'b0;
        frame_start  = 1'b0;
    endtask

    always @(negedge clk) begin
        automatic int lvl = wr_count / NW - released;
        automatic bit rdy = (lvl < 4);
        chk("wr_ready", bus.wr_ready, rdy);
        chk("wren", bus.wren, bus.wr_valid && rdy);
        chk("wraddr", bus.wraddr, wr_count % NW);
        chk("wrbuf", bus.wrbuf, (wr_count / NW) % 4);
        chk("rdaddr", bus.rdaddr, rd_pos);
        chk("rdbuf", bus.rdbuf, released % 4);
        chk("rd_busy", bus.rd_busy, m_busy);
        chk("rd_valid", bus.rd_valid, m_rv);
        chk("level", bus.level, lvl);
        chk("overflow", bus.overflow, m_ov);
        chk("underrun", bus.underrun, m_un);
    end

    task automatic setup_mid_bank();
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        for (int i = 0; i < 33; i++) step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < NW; i++) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        chk("setup_wraddr", bus.wraddr, 5);
        chk("setup_busy", bus.rd_busy, 1);
        chk("setup_ovf", bus.overflow, 1);
        chk("setup_unr", bus.underrun, 1);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_wraddr"}, bus.wraddr, 0);
        chk({tag, "_wrbuf"}, bus.wrbuf, 0);
        chk({tag, "_rdaddr"}, bus.rdaddr, 0);
        chk({tag, "_rdbuf"}, bus.rdbuf, 0);
        chk({tag, "_level"}, bus.level, 0);
        chk({tag, "_busy"}, bus.rd_busy, 0);
        chk({tag, "_ovf"}, bus.overflow, 0);
        chk({tag, "_unr"}, bus.underrun, 0);
        chk({tag, "_ready"}, bus.wr_ready, 1);
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.rd_start = 1'b0;
        bus.rd_en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_cleared("reset");
        chk("reset_wren", bus.wren, 0);
        reset_n = 1'b1;

        // Write one bank.
        for (int i = 0; i < NW; i++) step(1, 0, 0, 0);
        chk("t1_wrbuf", bus.wrbuf, 1);
        chk("t1_level", bus.level, 1);

        // Read it back.
        step(0, 1, 0, 0);
        for (int i = 0; i < NW; i++) step(0, 0, 1, 0);
        chk("t2_rdbuf", bus.rdbuf, 1);
        chk("t2_level", bus.level, 0);
        chk("t2_busy", bus.rd_busy, 0);

        // Underrun with empty store.
        step(0, 1, 0, 0);
        chk("t5_unr", bus.underrun, 1);
        chk("t5_busy", bus.rd_busy, 0);
        chk("t5_rdbuf", bus.rdbuf, 1);
        step(0, 0, 0, 1);
        chk("t5_unr_clr", bus.underrun, 0);

        // Fill all four banks, then overflow.
        for (int i = 0; i < 32; i++) step(1, 0, 0, 0);
        chk("t3_level", bus.level, 4);
        chk("t3_ready", bus.wr_ready, 0);
        chk("t3_wrbuf", bus.wrbuf, 0);
        chk("t3_full_eq", bus.wrbuf, bus.rdbuf);
        step(1, 0, 0, 0);
        chk("t3_ovf", bus.overflow, 1);
        chk("t3_wraddr", bus.wraddr, 0);
        chk("t3_wrbuf_hold", bus.wrbuf, 0);

        // Drain two banks, then commit and release on the same edge.
        for (int b = 0; b < 2; b++) begin
            step(0, 1, 0, 0);
            for (int i = 0; i < NW; i++) step(0, 0, 1, 0);
        end
        chk("t4_level_pre", bus.level, 2);
        step(0, 1, 0, 0);
        for (int i = 0; i < NW; i++) step(1, 0, 1, 0);
        chk("t4_level", bus.level, 2);
        chk("t4_wrbuf", bus.wrbuf, 1);
        chk("t4_rdbuf", bus.rdbuf, 3);

        // Asynchronous reset mid-bank.
        setup_mid_bank();
        reset_n = 1'b0;
        m_reset();
        #1;
        chk_cleared("areset");
        step(0, 0, 0, 0);
        reset_n = 1'b1;

        // Same via frame_start.
        setup_mid_bank();
        step(0, 0, 0, 1);
        chk_cleared("fstart");

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
